// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU execution controller.
package cpu_ctrl_pkg;

  // Controller state; the encoding is also the externally visible mode code.
  typedef enum logic [1:0] {
    HALT     = 2'b00,
    RUN      = 2'b01,
    STEP_CYC = 2'b10,
    STEP_INS = 2'b11
  } mode_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// single-cycle strobe on an accepted press. Releases give no strobe.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;

  // Synchronize, then count consecutive stable cycles that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= 1'b0;
      if ((sync2 == level) || (sync2 != prev)) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/halt/single-step controller for the CPU core: button conditioning,
// clock-enable generation, opcode-fetch breakpoint and enabled-cycle counter.
// Button commands are single-cycle strobes; halt beats step beats run.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             halt_btn,
  input  logic             step_btn,
  input  logic             step_instr,
  input  logic             sync,
  input  logic [15:0]      addr_bus,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_count,
  output logic             bp_hit
);

  logic [2:0] unused_level;
  logic       run_p;
  logic       halt_p;
  logic       step_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .rst(rst), .raw(run_btn), .level(unused_level[0]), .pulse(run_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (
    .clk(clk), .rst(rst), .raw(halt_btn), .level(unused_level[1]), .pulse(halt_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .rst(rst), .raw(step_btn), .level(unused_level[2]), .pulse(step_p)
  );

  mode_t state;
  mode_t state_n;
  logic  first;
  logic  first_n;
  logic  bp_hit_n;
  logic  bp_match;

  // 'first' masks the breakpoint on the resume cycle so a stop address can be executed.
  assign bp_match = bp_en && sync && (addr_bus == bp_addr) && !first;
  assign mode     = state;

  // Next state, clock enable and breakpoint flag from the current state and strobes.
  always_comb begin
    state_n  = state;
    first_n  = 1'b0;
    bp_hit_n = bp_hit;
    cpu_en   = 1'b0;
    if (halt_p) begin
      state_n = HALT;
    end else begin
      case (state)
        HALT: begin
          if (step_p) begin
            bp_hit_n = 1'b0;
            if (step_instr) begin
              state_n = STEP_INS;
              first_n = 1'b1;
            end else begin
              state_n = STEP_CYC;
            end
          end else if (run_p) begin
            state_n  = RUN;
            first_n  = 1'b1;
            bp_hit_n = 1'b0;
          end
        end
        RUN: begin
          if (bp_match) begin
            state_n  = HALT;
            bp_hit_n = 1'b1;
          end else begin
            cpu_en = 1'b1;
          end
        end
        STEP_CYC: begin
          cpu_en  = 1'b1;
          state_n = HALT;
        end
        STEP_INS: begin
          // Stop before the next opcode fetch executes, leaving the CPU poised on it.
          if (first || !sync) begin
            cpu_en = 1'b1;
          end else begin
            state_n = HALT;
          end
        end
        default: state_n = HALT;
      endcase
    end
  end

  // State register, flags and free-running enabled-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HALT;
      first       <= 1'b0;
      bp_hit      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state  <= state_n;
      first  <= first_n;
      bp_hit <= bp_hit_n;
      if (cpu_en) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: random/directed button and bus stimulus, a
// window-based reference model feeding an expected queue, and a monitor.
module tb_cpu_step_ctrl;

  localparam int DB = 4;
  localparam int CW = 8;
  localparam int EW = 2 + 1 + CW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          run_btn, halt_btn, step_btn, step_instr;
  logic          sync, bp_en;
  logic [15:0]   addr_bus, bp_addr;
  logic          cpu_en, bp_hit;
  logic [1:0]    mode;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .run_btn(run_btn), .halt_btn(halt_btn), .step_btn(step_btn),
    .step_instr(step_instr), .sync(sync), .addr_bus(addr_bus),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_en(cpu_en), .mode(mode), .cycle_count(cycle_count), .bp_hit(bp_hit)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_mis = 0;

  // ---------------- reference model state ----------------
  // hist[b] bit k = raw level of button b, k+1 cycles ago.
  logic [31:0] hist[3];
  int m_lvl[3];
  int m_state;      // 0 halt, 1 run, 2 step-cycle, 3 step-instruction
  bit m_first;
  bit m_bp;
  int m_cnt;
  int bus_mode;     // 0 hold, 1 random, 2 walking 8000..8003 with fetch at 8003
  int walk;

  // One cycle: choose bus inputs, predict outputs for this cycle, advance model, step clock.
  task automatic cyc();
    bit raw[3];
    bit pul[3];
    logic [DB:0] win;
    bit en, nfirst, nbp, bpc;
    int nxt;
    logic [1:0] ms;
    logic [CW-1:0] mc;
    if (bus_mode == 1) begin
      addr_bus = 16'h8000 + 16'($urandom_range(0, 3));
      sync     = ($urandom_range(0, 2) == 0);
    end else if (bus_mode == 2) begin
      addr_bus = 16'h8000 + 16'(walk % 4);
      sync     = ((walk % 4) == 3);
      walk++;
    end
    raw[0] = run_btn;
    raw[1] = halt_btn;
    raw[2] = step_btn;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        hist[b]  = '0;
        m_lvl[b] = 0;
      end
      m_state = 0;
      m_first = 1'b0;
      m_bp    = 1'b0;
      m_cnt   = 0;
    end else begin
      // A level is accepted once the synchronized input (raw delayed two cycles)
      // has held one value for DB+1 consecutive cycles that differs from it.
      for (int b = 0; b < 3; b++) begin
        win    = hist[b][2+DB:2];
        pul[b] = 1'b0;
        if (win == '0 && m_lvl[b] == 1) begin
          m_lvl[b] = 0;
        end else if (win == '1 && m_lvl[b] == 0) begin
          m_lvl[b] = 1;
          pul[b]   = 1'b1;
        end
      end
      en     = 1'b0;
      nxt    = m_state;
      nfirst = 1'b0;
      nbp    = m_bp;
      bpc    = bp_en && sync && (addr_bus == bp_addr) && !m_first;
      if (pul[1]) begin
        nxt = 0;
      end else begin
        case (m_state)
          0: begin
            if (pul[2]) begin
              nbp    = 1'b0;
              nxt    = step_instr ? 3 : 2;
              nfirst = step_instr;
            end else if (pul[0]) begin
              nbp    = 1'b0;
              nxt    = 1;
              nfirst = 1'b1;
            end
          end
          1: begin
            if (bpc) begin
              nxt = 0;
              nbp = 1'b1;
            end else begin
              en = 1'b1;
            end
          end
          2: begin
            en  = 1'b1;
            nxt = 0;
          end
          default: begin
            if (m_first || !sync) en = 1'b1;
            else nxt = 0;
          end
        endcase
      end
      ms = m_state[1:0];
      mc = m_cnt[CW-1:0];
      exp_q.push_back({ms, en, mc, m_bp});
      m_state = nxt;
      m_first = nfirst;
      m_bp    = nbp;
      m_cnt   = (m_cnt + int'(en)) % (1 << CW);
      for (int b = 0; b < 3; b++) begin
        hist[b] = {hist[b][30:0], raw[b]};
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) run_btn = 1'b1;
    else if (which == 1) halt_btn = 1'b1;
    else step_btn = 1'b1;
    repeat (hold) cyc();
    run_btn  = 1'b0;
    halt_btn = 1'b0;
    step_btn = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] e;

  // Compare DUT outputs mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL no_expectation at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (mode !== e[EW-1:EW-2]) begin
          n_mis++;
          $display("FAIL mode at %0t: got %0d expected %0d", $time, mode, e[EW-1:EW-2]);
        end
        if (cpu_en !== e[EW-3]) begin
          n_mis++;
          $display("FAIL cpu_en at %0t: got %0b expected %0b", $time, cpu_en, e[EW-3]);
        end
        if (cycle_count !== e[CW:1]) begin
          n_mis++;
          $display("FAIL cycle_count at %0t: got %0d expected %0d", $time, cycle_count, e[CW:1]);
        end
        if (bp_hit !== e[0]) begin
          n_mis++;
          $display("FAIL bp_hit at %0t: got %0b expected %0b", $time, bp_hit, e[0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    run_btn    = 1'b0;
    halt_btn   = 1'b0;
    step_btn   = 1'b0;
    step_instr = 1'b0;
    sync       = 1'b0;
    addr_bus   = 16'h0000;
    bp_en      = 1'b0;
    bp_addr    = 16'h8003;
    bus_mode   = 0;
    walk       = 0;
    repeat (3) cyc();
    rst = 1'b0;
    idle(4);

    // Run from halt, then halt.
    bus_mode = 1;
    press(0, 10);
    idle(20);
    press(1, 8);
    idle(6);

    // Single cycle step.
    step_instr = 1'b0;
    press(2, 7);
    idle(6);

    // Instruction steps with random fetch pattern.
    step_instr = 1'b1;
    repeat (4) begin
      press(2, 7);
      idle(12);
    end

    // Breakpoint at 8003, then resume over it, then halt.
    bp_en    = 1'b1;
    bus_mode = 2;
    walk     = 0;
    press(0, 7);
    idle(20);
    press(0, 7);
    idle(10);
    press(1, 7);
    idle(6);

    // Short glitch is ignored.
    press(0, 3);
    idle(10);

    // Simultaneous run and halt while halted.
    run_btn  = 1'b1;
    halt_btn = 1'b1;
    repeat (8) cyc();
    run_btn  = 1'b0;
    halt_btn = 1'b0;
    idle(8);

    // Reset in the middle of a run.
    bp_en = 1'b0;
    press(0, 7);
    idle(5);
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    idle(8);

    // Long run to wrap the counter.
    bus_mode = 1;
    press(0, 7);
    idle(300);
    press(1, 7);
    idle(5);

    // Random button activity.
    repeat (80) begin
      step_instr = 1'($urandom_range(0, 1));
      bp_en      = 1'($urandom_range(0, 1));
      press(int'($urandom_range(0, 2)), int'($urandom_range(1, 9)));
      idle(int'($urandom_range(0, 14)));
    end

    // Drain the expected queue within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
